// File: rtl/tt_resp_pkg.sv
// Shared types and constants for the fabric-to-project REQ/ACK responder.
package tt_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ACK_CMD   = 2'b01,
        ST_WAIT_DATA = 2'b10,
        ST_ACK_DATA  = 2'b11
    } state_t;

    typedef struct packed {
        logic       wr;
        logic [2:0] rsvd;
        logic [3:0] addr;
    } cmd_t;

    localparam logic [3:0] ADDR_ID  = 4'd8;
    localparam logic [3:0] ADDR_CNT = 4'd9;

    localparam int REQ_BIT = 0;
    localparam int ACK_BIT = 1;
    localparam int ERR_BIT = 2;
    localparam int ST_LSB  = 3;

    localparam logic [7:0] UIO_OE_RUN = 8'hFE;

endpackage

// File: rtl/tt_resp_sync.sv
// Flop chain that brings the fabric REQ into the UserCLK domain.
module tt_resp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic UserCLK,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            chain <= '0;
        end else begin
            // Shift left, new sample enters at bit 0; works for a single stage too.
            chain <= SYNC_STAGES'({chain, d});
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/tt_fabric_responder.sv
// Project-side responder: byte register file behind a 4-phase REQ/ACK handshake on uio[1:0].
module tt_fabric_responder
    import tt_resp_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         NUM_REGS    = 8,
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter int         TIMEOUT_CYC = 255
) (
    input  logic       UserCLK,
    input  logic       Reset,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t         state_q, state_d;
    logic           req_s;
    logic           armed_q;
    logic           accept;
    cmd_t           cmd_in;
    logic           cmd_wr_q;
    logic [3:0]     cmd_addr_q;
    logic [7:0]     regs_q [8];
    logic [7:0]     cnt_q;
    logic [TW-1:0]  tmo_q;
    logic           tmo_hit;
    logic           err_q;
    logic           ack_q;
    logic [7:0]     rdata_q;
    logic [7:0]     oe_q;
    logic [7:0]     rd_value;
    logic           rd_valid;
    logic           wr_valid;

    logic           latch_cmd;
    logic           rd_load;
    logic           wr_data;
    logic           cnt_inc;
    logic           err_set;
    logic           err_clr;
    logic           tmo_clr;
    logic           tmo_inc;

    logic           unused_bits;

    tt_resp_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .UserCLK (UserCLK),
        .Reset   (Reset),
        .d       (uio_in[REQ_BIT]),
        .q       (req_s)
    );

    assign cmd_in  = cmd_t'(ui_in);
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC));
    // armed_q remembers req_s was low last cycle, so only a fresh rise starts a command.
    assign accept  = (state_q == ST_IDLE) && req_s && ena && armed_q;

    assign unused_bits = ^{cmd_in.rsvd, uio_in[7:1]};

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        rd_value = '0;
        rd_valid = 1'b1;
        if (int'(cmd_in.addr) < NUM_REGS) begin
            rd_value = regs_q[cmd_in.addr[2:0]];
        end else if (cmd_in.addr == ADDR_ID) begin
            rd_value = ID_VALUE;
        end else if (cmd_in.addr == ADDR_CNT) begin
            rd_value = cnt_q;
        end else begin
            rd_valid = 1'b0;
        end
    end

    assign wr_valid = (int'(cmd_addr_q) < NUM_REGS);

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_ACK_CMD;
            end
            ST_ACK_CMD: begin
                if (!req_s) state_d = cmd_wr_q ? ST_WAIT_DATA : ST_IDLE;
            end
            ST_WAIT_DATA: begin
                if (req_s) begin
                    state_d = ST_ACK_DATA;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK_DATA: begin
                if (!req_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        latch_cmd = 1'b0;
        rd_load   = 1'b0;
        wr_data   = 1'b0;
        cnt_inc   = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        tmo_clr   = 1'b0;
        tmo_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    latch_cmd = 1'b1;
                    if (!cmd_in.wr) begin
                        rd_load = 1'b1;
                        err_set = !rd_valid;
                    end
                end
            end
            ST_ACK_CMD: begin
                if (!req_s) begin
                    if (cmd_wr_q) begin
                        tmo_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                        err_clr = (cmd_addr_q == ADDR_CNT);
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (req_s) begin
                    wr_data = 1'b1;
                    err_set = !wr_valid;
                end else if (tmo_hit) begin
                    err_set = 1'b1;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            ST_ACK_DATA: begin
                if (!req_s) cnt_inc = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            oe_q       <= '0;
            armed_q    <= 1'b0;
            ack_q      <= 1'b0;
            cmd_wr_q   <= 1'b0;
            cmd_addr_q <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            // NOTE: the register file is cleared on reset because software relies on reading zeros.
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            oe_q    <= UIO_OE_RUN;
            armed_q <= !req_s;
            ack_q   <= (state_d == ST_ACK_CMD) || (state_d == ST_ACK_DATA);

            if (latch_cmd) begin
                cmd_wr_q   <= cmd_in.wr;
                cmd_addr_q <= cmd_in.addr;
            end
            if (rd_load) begin
                rdata_q <= rd_value;
            end
            if (wr_data && wr_valid) begin
                regs_q[cmd_addr_q[2:0]] <= ui_in;
            end
            if (cnt_inc) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (tmo_clr) begin
                tmo_q <= '0;
            end else if (tmo_inc) begin
                tmo_q <= tmo_q + TW'(1);
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign uo_out  = rdata_q;
    assign uio_oe  = oe_q;
    assign uio_out = {3'b000, state_q, err_q, ack_q, 1'b0};

endmodule

// File: tb/tb_tt_fabric_responder.sv
// Directed plus randomized bench for tt_fabric_responder against a register-file reference model.
module tb_tt_fabric_responder;

    localparam int         SYNC_STAGES = 2;
    localparam int         NUM_REGS    = 8;
    localparam logic [7:0] ID_VALUE    = 8'hA5;
    localparam int         TIMEOUT_CYC = 255;
    localparam int         ACK_B       = 1;
    localparam int         ERR_B       = 2;

    logic       UserCLK = 1'b0;
    logic       Reset;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [7:0] m_regs [NUM_REGS];
    logic [7:0] m_cnt;
    logic       m_err;

    always #5 UserCLK = ~UserCLK;

    tt_fabric_responder #(
        .SYNC_STAGES (SYNC_STAGES),
        .NUM_REGS    (NUM_REGS),
        .ID_VALUE    (ID_VALUE),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .UserCLK (UserCLK),
        .Reset   (Reset),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_value(input logic [3:0] a);
        if (int'(a) < NUM_REGS) return m_regs[a[2:0]];
        if (a == 4'd8) return ID_VALUE;
        if (a == 4'd9) return m_cnt;
        return 8'h00;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_cnt = 8'h00;
        m_err = 1'b0;
    endtask

    task automatic wait_ack(input logic v, input string tag);
        int n = 0;
        while (uio_out[ACK_B] !== v && n < 32) begin
            @(negedge UserCLK);
            n++;
        end
        check(tag, {7'd0, uio_out[ACK_B]}, {7'd0, v});
    endtask

    task automatic do_read(input logic [3:0] a, input string tag);
        logic [7:0] exp;
        exp = m_value(a);
        ui_in     = {1'b0, 3'($urandom), a};
        uio_in[0] = 1'b1;
        wait_ack(1'b1, "rd_ack_high");
        check(tag, uo_out, exp);
        check("uio_rsvd", uio_out & 8'hE1, 8'h00);
        if (!(int'(a) < NUM_REGS || a == 4'd8 || a == 4'd9)) m_err = 1'b1;
        m_cnt = m_cnt + 8'd1;
        if (a == 4'd9) m_err = 1'b0;
        uio_in[0] = 1'b0;
        wait_ack(1'b0, "rd_ack_low");
        check("rd_err", {7'd0, uio_out[ERR_B]}, {7'd0, m_err});
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        ui_in     = {1'b1, 3'($urandom), a};
        uio_in[0] = 1'b1;
        wait_ack(1'b1, "wr_cmd_ack_high");
        uio_in[0] = 1'b0;
        wait_ack(1'b0, "wr_cmd_ack_low");
        check("wr_state_wait", {6'd0, uio_out[4:3]}, 8'd2);
        ui_in     = d;
        uio_in[0] = 1'b1;
        wait_ack(1'b1, "wr_dat_ack_high");
        if (int'(a) < NUM_REGS) m_regs[a[2:0]] = d;
        else m_err = 1'b1;
        m_cnt = m_cnt + 8'd1;
        uio_in[0] = 1'b0;
        wait_ack(1'b0, "wr_dat_ack_low");
        check("wr_err", {7'd0, uio_out[ERR_B]}, {7'd0, m_err});
    endtask

    initial begin
        int n;
        logic seen;
        m_reset();
        Reset  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(negedge UserCLK);
        check("rst_uo_out", uo_out, 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'h00);
        Reset = 1'b0;
        @(negedge UserCLK);
        check("run_uio_oe", uio_oe, 8'hFE);
        check("run_uio_out", uio_out, 8'h00);
        repeat (2) @(negedge UserCLK);

        // Write/read round trip and transaction count
        do_write(4'd2, 8'h3C);
        do_read(4'd2, "rd_reg2");
        check("err_clean", {7'd0, uio_out[ERR_B]}, 8'd0);
        do_read(4'd9, "rd_cnt_2");

        // ID read with ACK latency measured from the raw REQ rise
        repeat (3) @(negedge UserCLK);
        ui_in     = 8'h08;
        uio_in[0] = 1'b1;
        n = 0;
        while (uio_out[ACK_B] !== 1'b1 && n < 16) begin
            @(negedge UserCLK);
            n++;
        end
        check("ack_latency", 8'(n), 8'(SYNC_STAGES + 1));
        check("rd_id", uo_out, ID_VALUE);
        m_cnt = m_cnt + 8'd1;
        uio_in[0] = 1'b0;
        wait_ack(1'b0, "id_ack_low");

        // Invalid address sets sticky ERR; reading the count clears it
        do_read(4'hC, "rd_invalid");
        check("err_sticky", {7'd0, uio_out[ERR_B]}, 8'd1);
        do_read(4'd9, "rd_cnt_clr");

        // Write timeout: command accepted, data never arrives
        do_write(4'd1, 8'h5A);
        ui_in     = 8'h81;
        uio_in[0] = 1'b1;
        wait_ack(1'b1, "to_ack_high");
        uio_in[0] = 1'b0;
        wait_ack(1'b0, "to_ack_low");
        repeat (TIMEOUT_CYC) @(negedge UserCLK);
        check("to_still_wait", {6'd0, uio_out[4:3]}, 8'd2);
        @(negedge UserCLK);
        check("to_idle", {6'd0, uio_out[4:3]}, 8'd0);
        check("to_err", {7'd0, uio_out[ERR_B]}, 8'd1);
        m_err = 1'b1;
        do_read(4'd1, "to_reg1_kept");
        do_read(4'd9, "to_cnt_kept");

        // ena gating and edge qualification of REQ
        ena       = 1'b0;
        ui_in     = 8'h03;
        uio_in[0] = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge UserCLK);
            seen |= uio_out[ACK_B];
        end
        check("ena_low_no_ack", {7'd0, seen}, 8'd0);
        ena = 1'b1;
        repeat (10) begin
            @(negedge UserCLK);
            seen |= uio_out[ACK_B];
        end
        check("ena_high_held_req", {7'd0, seen}, 8'd0);
        uio_in[0] = 1'b0;
        repeat (4) @(negedge UserCLK);
        do_read(4'd3, "ena_rearmed_rd");

        // Randomized traffic over the whole address space
        for (int t = 0; t < 40; t++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 15));
            uio_in[7:1] = 7'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom));
            else do_read(a, "rand_rd");
        end
        uio_in[7:1] = 7'd0;
        do_read(4'd9, "rand_cnt");

        // Reset in the middle of a write
        ui_in     = 8'h84;
        uio_in[0] = 1'b1;
        wait_ack(1'b1, "mid_ack_high");
        uio_in[0] = 1'b0;
        wait_ack(1'b0, "mid_ack_low");
        check("mid_state_wait", {6'd0, uio_out[4:3]}, 8'd2);
        Reset = 1'b1;
        @(negedge UserCLK);
        check("mid_rst_uio_out", uio_out, 8'h00);
        check("mid_rst_uio_oe", uio_oe, 8'h00);
        check("mid_rst_uo_out", uo_out, 8'h00);
        Reset = 1'b0;
        m_reset();
        @(negedge UserCLK);
        check("mid_run_uio_oe", uio_oe, 8'hFE);
        repeat (2) @(negedge UserCLK);
        for (int i = 0; i < NUM_REGS; i++) do_read(4'(i), "post_rst_reg");
        do_read(4'd9, "post_rst_cnt");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
